// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI bridge.
// Holds the fixed AXI field values driven by the top shell, the default
// read IDs for the two CPU ports, and the state encodings of both FSMs.
package cpu_axi_bridge_pkg;

    // Fixed AXI3 fields: single-beat INCR transfers, normal access.
    localparam logic [3:0] AXI_LEN        = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK       = 2'b00;
    localparam logic [3:0] AXI_CACHE      = 4'b0000;
    localparam logic [2:0] AXI_PROT       = 3'b000;
    localparam logic [3:0] AXI_WID        = 4'd1;
    localparam logic       AXI_WLAST      = 1'b1;

    // Default ARID/RID tags for the two request sources.
    localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

    // Instruction fetches are always full words.
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

endpackage

// File: rtl/cpu_axi_bridge_write_ch.sv
// Write channel of the CPU-to-AXI bridge (module axi_write_ch).
// Latches one store on start, presents AW and W together, drops each
// valid independently after its own handshake, then waits for B and
// pulses done for one cycle.
// Ports:
//   clk, reset                      clock, async active-high reset
//   start                           store accepted this cycle
//   addr, size, strb, data          store fields captured on start
//   idle                            FSM can accept a new store
//   awaddr/awsize/awvalid/awready   AXI AW channel
//   wdata/wstrb/wvalid/wready       AXI W channel
//   bvalid/bready                   AXI B channel
//   done                            one-cycle pulse after the B handshake
module axi_write_ch
    import cpu_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  strb,
    input  logic [31:0] data,
    output logic        idle,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic        done
);

    w_state_t w_state;

    // A channel counts as finished if it already dropped valid or handshakes now.
    logic aw_finished;
    logic w_finished;

    assign aw_finished = ~awvalid | awready;
    assign w_finished  = ~wvalid  | wready;
    assign idle        = (w_state == W_IDLE);

    // NOTE: every register in this block, datapath included, is updated with
    // non-blocking assignments so all of them sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            awaddr  <= '0;
            awsize  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (start) begin
                        awaddr  <= addr;
                        awsize  <= {1'b0, size};
                        wstrb   <= strb;
                        wdata   <= data;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        w_state <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_finished && w_finished) begin
                        bready  <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        done    <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// CPU-to-AXI bridge: merges the instruction (read-only) and data
// (read/write) SRAM-style ports onto one AXI3-subset master.
// One read in flight on AR/R, one write on AW/W/B, one data-port
// transaction overall; a store and an instruction fetch may overlap.
// Ports:
//   clk, reset                        clock, async active-high reset
//   inst_*                            instruction request/ack port
//   data_*                            data request/ack port
//   arid/araddr/arsize/arvalid/arready, rid/rdata/rvalid/rready   AXI read
//   awaddr/awsize/awvalid/awready, wdata/wstrb/wvalid/wready,
//   bvalid/bready                     AXI write
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
    parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    r_state_t r_state;
    logic     data_busy;
    logic     rd_data_ok;
    logic     wr_data_ok;
    logic     w_idle;
    logic     data_rd_win;
    logic     data_wr_win;
    logic     data_accept;

    // Data reads outrank instruction fetches; nothing new on the data port
    // while an earlier data access is still unanswered.
    assign data_rd_win  = ~data_busy & data_req & ~data_wr & (r_state == R_IDLE);
    assign data_wr_win  = ~data_busy & data_req &  data_wr & w_idle;
    assign data_addr_ok = ~reset & (data_rd_win | data_wr_win);
    assign inst_addr_ok = ~reset & (r_state == R_IDLE) & ~data_rd_win;
    assign data_accept  = data_req & data_addr_ok;

    // Only one data transaction can be outstanding, so the two sources never collide.
    assign data_data_ok = rd_data_ok | wr_data_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             data_busy <= 1'b0;
        else if (data_accept)  data_busy <= 1'b1;
        else if (data_data_ok) data_busy <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= R_IDLE;
            arid         <= '0;
            araddr       <= '0;
            arsize       <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
            inst_data_ok <= 1'b0;
            rd_data_ok   <= 1'b0;
        end else begin
            inst_data_ok <= 1'b0;
            rd_data_ok   <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (data_rd_win) begin
                        arid    <= DATA_ID;
                        araddr  <= data_addr;
                        arsize  <= {1'b0, data_size};
                        arvalid <= 1'b1;
                        r_state <= R_AR;
                    end else if (inst_req) begin
                        arid    <= INST_ID;
                        araddr  <= inst_addr;
                        arsize  <= SIZE_WORD;
                        arvalid <= 1'b1;
                        r_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_R;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        r_state <= R_IDLE;
                        // An unknown rid is dropped without an acknowledge.
                        if (rid == INST_ID) begin
                            inst_rdata   <= rdata;
                            inst_data_ok <= 1'b1;
                        end else if (rid == DATA_ID) begin
                            data_rdata <= rdata;
                            rd_data_ok <= 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_write_ch u_write_ch (
        .clk     (clk),
        .reset   (reset),
        .start   (data_wr_win & data_req & ~reset),
        .addr    (data_addr),
        .size    (data_size),
        .strb    (data_wstrb),
        .data    (data_wdata),
        .idle    (w_idle),
        .awaddr  (awaddr),
        .awsize  (awsize),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready),
        .done    (wr_data_ok)
    );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed testbench for cpu_axi_bridge. The bench plays the CPU and the
// AXI slave cycle by cycle; expected values are hand-derived constants.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;

    int total = 0;
    int bad   = 0;

    cpu_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Slave side of one read: grant AR when it shows up, then return R with the given rid/data.
    // Returns just after the edge that registers the read data (the data_ok cycle).
    task automatic serve_read(input logic [3:0] id, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (arvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (arvalid !== 1'b1) begin
            bad++;
            $display("FAIL serve_read_ar_timeout: arvalid=%0b want 1", arvalid);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        n = 0;
        @(negedge clk);
        while (rready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rready !== 1'b1) begin
            bad++;
            $display("FAIL serve_read_r_timeout: rready=%0b want 1", rready);
        end
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok,
             inst_data_ok, data_data_ok} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok,
                      inst_data_ok, data_data_ok});
        end
        total++;
        if ({inst_rdata, data_rdata, araddr, awaddr, wdata} !== 160'h0) begin
            bad++;
            $display("FAIL reset_data: inst_rdata=%h data_rdata=%h araddr=%h awaddr=%h wdata=%h want 0",
                     inst_rdata, data_rdata, araddr, awaddr, wdata);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_inst_read;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0000;
        @(negedge clk);                                     // cycle 0
        total++;
        if (inst_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL inst_accept: inst_addr_ok=%0b want 1", inst_addr_ok);
        end
        tick();
        inst_req = 1'b0;
        arready  = 1'b1;
        @(negedge clk);                                     // cycle 1
        total++;
        if ({arvalid, arid, arsize, araddr} !== {1'b1, 4'd0, 3'd2, 32'h1c00_0000}) begin
            bad++;
            $display("FAIL inst_ar: valid=%0b id=%0d size=%0d addr=%h want 1 0 2 1c000000",
                     arvalid, arid, arsize, araddr);
        end
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rid     = 4'd0;
        rdata   = 32'h0280_0c04;
        @(negedge clk);                                     // cycle 2
        total++;
        if ({arvalid, rready, inst_data_ok} !== 3'b010) begin
            bad++;
            $display("FAIL inst_r_phase: arvalid,rready,data_ok=%b want 010",
                     {arvalid, rready, inst_data_ok});
        end
        tick();
        rvalid = 1'b0;
        @(negedge clk);                                     // cycle 3
        total++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h0280_0c04}) begin
            bad++;
            $display("FAIL inst_data: inst_ok=%0b data_ok=%0b rdata=%h want 1 0 02800c04",
                     inst_data_ok, data_data_ok, inst_rdata);
        end
        tick();
        @(negedge clk);                                     // cycle 4
        total++;
        if ({inst_data_ok, rready} !== 2'b00) begin
            bad++;
            $display("FAIL inst_pulse_width: inst_data_ok,rready=%b want 00", {inst_data_ok, rready});
        end
        tick();
    endtask

    task automatic test_priority;
        inst_req   = 1'b1;
        inst_addr  = 32'h1c00_0004;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h8000_1000;
        @(negedge clk);
        total++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
            bad++;
            $display("FAIL prio_accept: data_ok,inst_ok=%b want 10", {data_addr_ok, inst_addr_ok});
        end
        tick();
        data_req = 1'b0;
        arready  = 1'b1;
        @(negedge clk);
        total++;
        if ({arvalid, arid, arsize, araddr, inst_addr_ok} !== {1'b1, 4'd1, 3'd2, 32'h8000_1000, 1'b0}) begin
            bad++;
            $display("FAIL prio_ar: valid=%0b id=%0d size=%0d addr=%h inst_ok=%0b want 1 1 2 80001000 0",
                     arvalid, arid, arsize, araddr, inst_addr_ok);
        end
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rid     = 4'd1;
        rdata   = 32'hdead_beef;
        @(negedge clk);
        total++;
        if (inst_addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL prio_inst_blocked: inst_addr_ok=%0b want 0", inst_addr_ok);
        end
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({data_data_ok, inst_data_ok, data_rdata, inst_addr_ok} !== {2'b10, 32'hdead_beef, 1'b1}) begin
            bad++;
            $display("FAIL prio_data_ok: data_ok=%0b inst_ok=%0b rdata=%h inst_addr_ok=%0b want 1 0 deadbeef 1",
                     data_data_ok, inst_data_ok, data_rdata, inst_addr_ok);
        end
        tick();                                             // inst accepted at this edge
        inst_req = 1'b0;
        @(negedge clk);
        total++;
        if ({arvalid, arid, arsize, araddr} !== {1'b1, 4'd0, 3'd2, 32'h1c00_0004}) begin
            bad++;
            $display("FAIL prio_inst_ar: valid=%0b id=%0d size=%0d addr=%h want 1 0 2 1c000004",
                     arvalid, arid, arsize, araddr);
        end
        serve_read(4'd0, 32'h1234_5678);
        @(negedge clk);
        total++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h1234_5678}) begin
            bad++;
            $display("FAIL prio_inst_data: ok=%0b rdata=%h want 1 12345678", inst_data_ok, inst_rdata);
        end
        tick();
    endtask

    task automatic test_byte_store;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_addr  = 32'h8000_0003;
        data_wstrb = 4'b1000;
        data_wdata = 32'h5500_0000;
        @(negedge clk);                                     // cycle 0
        total++;
        if (data_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL store_accept: data_addr_ok=%0b want 1", data_addr_ok);
        end
        tick();
        data_req = 1'b0;
        awready  = 1'b1;
        @(negedge clk);                                     // cycle 1
        total++;
        if ({awvalid, wvalid, awaddr, awsize, wstrb, wdata} !==
            {2'b11, 32'h8000_0003, 3'd0, 4'b1000, 32'h5500_0000}) begin
            bad++;
            $display("FAIL store_aw_w: awv=%0b wv=%0b addr=%h size=%0d strb=%b data=%h want 1 1 80000003 0 1000 55000000",
                     awvalid, wvalid, awaddr, awsize, wstrb, wdata);
        end
        tick();
        awready = 1'b0;
        @(negedge clk);                                     // cycle 2
        total++;
        if ({awvalid, wvalid, bready} !== 3'b010) begin
            bad++;
            $display("FAIL store_aw_done: awv,wv,bready=%b want 010", {awvalid, wvalid, bready});
        end
        tick();
        wready = 1'b1;
        @(negedge clk);                                     // cycle 3
        total++;
        if ({awvalid, wvalid, bready} !== 3'b010) begin
            bad++;
            $display("FAIL store_w_wait: awv,wv,bready=%b want 010", {awvalid, wvalid, bready});
        end
        tick();
        wready = 1'b0;
        bvalid = 1'b1;
        @(negedge clk);                                     // cycle 4
        total++;
        if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin
            bad++;
            $display("FAIL store_bready: awv,wv,bready,ok=%b want 0010", {awvalid, wvalid, bready, data_data_ok});
        end
        tick();
        bvalid = 1'b0;
        @(negedge clk);                                     // cycle 5
        total++;
        if ({data_data_ok, inst_data_ok, bready} !== 3'b100) begin
            bad++;
            $display("FAIL store_data_ok: data_ok,inst_ok,bready=%b want 100", {data_data_ok, inst_data_ok, bready});
        end
        tick();
        @(negedge clk);                                     // cycle 6
        total++;
        if (data_data_ok !== 1'b0) begin
            bad++;
            $display("FAIL store_pulse_width: data_data_ok=%0b want 0", data_data_ok);
        end
        tick();
    endtask

    task automatic test_write_then_read;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_2000;
        data_wstrb = 4'b1111;
        data_wdata = 32'ha5a5_5a5a;
        tick();                                             // store accepted
        data_wr   = 1'b0;                                   // load now pending
        data_addr = 32'h8000_2000;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0010;
        @(negedge clk);
        total++;
        if ({data_addr_ok, inst_addr_ok, awvalid} !== 3'b011) begin
            bad++;
            $display("FAIL raw_block: data_ok,inst_ok,awvalid=%b want 011", {data_addr_ok, inst_addr_ok, awvalid});
        end
        tick();
        inst_req = 1'b0;
        serve_read(4'd0, 32'h1111_2222);
        @(negedge clk);
        total++;
        if ({inst_data_ok, inst_rdata, data_addr_ok, data_data_ok} !== {1'b1, 32'h1111_2222, 2'b00}) begin
            bad++;
            $display("FAIL raw_inst_parallel: ok=%0b rdata=%h data_addr_ok=%0b data_ok=%0b want 1 11112222 0 0",
                     inst_data_ok, inst_rdata, data_addr_ok, data_data_ok);
        end
        tick();
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b1;
        @(negedge clk);
        total++;
        if ({bready, data_addr_ok} !== 2'b10) begin
            bad++;
            $display("FAIL raw_resp: bready,data_addr_ok=%b want 10", {bready, data_addr_ok});
        end
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({data_data_ok, data_addr_ok} !== 2'b10) begin
            bad++;
            $display("FAIL raw_write_done: data_ok,data_addr_ok=%b want 10", {data_data_ok, data_addr_ok});
        end
        tick();
        @(negedge clk);
        total++;
        if (data_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL raw_load_release: data_addr_ok=%0b want 1", data_addr_ok);
        end
        tick();
        data_req = 1'b0;
        serve_read(4'd1, 32'hcafe_f00d);
        @(negedge clk);
        total++;
        if ({data_data_ok, data_rdata, inst_data_ok} !== {1'b1, 32'hcafe_f00d, 1'b0}) begin
            bad++;
            $display("FAIL raw_load_data: ok=%0b rdata=%h inst_ok=%0b want 1 cafef00d 0",
                     data_data_ok, data_rdata, inst_data_ok);
        end
        tick();
    endtask

    task automatic test_reset_in_flight;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0020;
        tick();
        inst_req = 1'b0;
        arready  = 1'b1;
        tick();
        arready = 1'b0;
        @(negedge clk);
        total++;
        if (rready !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_rready: rready=%0b want 1", rready);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok,
             inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== 73'h0) begin
            bad++;
            $display("FAIL rst_async: ctrl=%b inst_rdata=%h data_rdata=%h want all 0",
                     {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok,
                      inst_data_ok, data_data_ok}, inst_rdata, data_rdata);
        end
        tick();
        tick();
        reset  = 1'b0;
        rvalid = 1'b1;                                      // stale response from the abandoned read
        rid    = 4'd0;
        rdata  = 32'h7777_7777;
        tick();
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({inst_data_ok, data_data_ok, arvalid, rready, inst_rdata} !== {4'b0000, 32'h0}) begin
                bad++;
                $display("FAIL rst_no_data_ok[%0d]: ok=%b arv=%0b rready=%0b rdata=%h want 00 0 0 0",
                         i, {inst_data_ok, data_data_ok}, arvalid, rready, inst_rdata);
            end
            tick();
        end
    endtask

    task automatic test_bad_rid;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0030;
        tick();
        inst_req = 1'b0;
        serve_read(4'd7, 32'hbad0_bad0);
        @(negedge clk);
        total++;
        if ({inst_data_ok, data_data_ok, inst_addr_ok, inst_rdata, data_rdata} !==
            {3'b001, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL badrid_drop: inst_ok=%0b data_ok=%0b inst_addr_ok=%0b inst_rdata=%h data_rdata=%h want 0 0 1 0 0",
                     inst_data_ok, data_data_ok, inst_addr_ok, inst_rdata, data_rdata);
        end
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0034;
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        total++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1c00_0034}) begin
            bad++;
            $display("FAIL badrid_next_ar: valid=%0b id=%0d addr=%h want 1 0 1c000034", arvalid, arid, araddr);
        end
        serve_read(4'd0, 32'h0011_2233);
        @(negedge clk);
        total++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0011_2233}) begin
            bad++;
            $display("FAIL badrid_next_data: ok=%0b rdata=%h want 1 00112233", inst_data_ok, inst_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_priority();
        test_byte_store();
        test_write_then_read();
        test_reset_in_flight();
        test_bad_rid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data SRAM-style ports; converts them to a single AXI3-subset master port.
- Two request/acknowledge ports: instruction read-only, data read/write. One shared read channel, one write channel.
- At most one outstanding read on AR/R, at most one outstanding write on AW/W/B, and at most one outstanding data-port transaction.

Parameters:
- INST_ID, 4'd0, ARID/RID value tagging instruction reads.
- DATA_ID, 4'd1, ARID/RID value tagging data reads.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  instruction read request
inst_addr  in  32  instruction address (word access, size 2)
inst_addr_ok  out  1  request accepted this cycle
inst_data_ok  out  1  read data valid pulse
inst_rdata  out  32  instruction word
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  4  write byte strobes
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  read data returned / write completed pulse
data_rdata  out  32  load data
arid  out  4  read ID
araddr  out  32  read address
arsize  out  3  read size
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  R ID
rdata  in  32  R data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  write address
awsize  out  3  write size
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Fixed AXI fields (len 0, burst INCR, lock/cache/prot 0, wid 1, wlast 1) are driven by the top shell from package constants; this block does not output them.
- Reset (async): both FSMs idle. Deasserted to 0: arvalid, rready, awvalid, wvalid, bready, all *_addr_ok, all *_data_ok. rdata outputs and latched address/data registers cleared to 0. The slave shares this reset; in-flight transactions are abandoned.
- Request handshake: a request is accepted when *_req and *_addr_ok are both high in the same cycle. addr_ok is combinational from FSM state and arbitration.
- Read FSM, R_IDLE -> R_AR -> R_R -> R_IDLE:
  - R_IDLE:
    - Data read is eligible when data_req & ~data_wr & no data transaction is outstanding.
    - Data read has priority over inst_req.
    - The winner gets addr_ok = 1. Latch araddr, arid, and arsize ({1'b0, data_size} for data, 3'd2 for inst). Next state R_AR.
  - R_AR: arvalid = 1, held stable until arready; then R_R.
  - R_R: rready = 1. On rvalid:
    - Register rdata into inst_rdata or data_rdata according to rid.
    - Pulse the matching *_data_ok for exactly 1 cycle, in the cycle after the R handshake.
    - Return to R_IDLE. A new request may be accepted in that same pulse cycle.
  - Minimum latency from accept to data_ok: 3 cycles with arready and rvalid immediate.
- Write FSM, W_IDLE -> W_SEND -> W_RESP -> W_IDLE:
  - W_IDLE: data_req & data_wr & no data transaction outstanding gives data_addr_ok = 1. Latch addr, size, wstrb, wdata.
  - W_SEND: awvalid and wvalid both asserted. Each deasserts independently after its own handshake. When both handshakes are done (same or different cycles), go to W_RESP.
  - W_RESP: bready = 1. On bvalid, pulse data_data_ok the next cycle and return to W_IDLE.
- "Data transaction outstanding" is set on data accept and cleared on the data_data_ok pulse. This rules out read-after-write hazards and data_data_ok collisions.
- A write and an instruction read may be in flight concurrently.
- Both data read and write requests are suppressed while either is outstanding.
- rid matching neither ID: data discarded, and the FSM still returns to R_IDLE (error case, no data_ok).
- inst_data_ok and data_data_ok are never both high from the read path in one cycle.

Decomposition:
- Shared package (mycpu.h): AXI constant defines (LEN 0, BURST INCR, etc.), INST_ID/DATA_ID defaults, and FSM state encodings R_IDLE/R_AR/R_R and W_IDLE/W_SEND/W_RESP.
- One natural sub-module: axi_write_ch, holding the write FSM plus AW/W/B handshake tracking. The read FSM and arbitration stay in the parent.

Test Plan:
- Inst read 0x1c000000, arready/rvalid immediate, rdata 0x02800c04 -> arid 0, inst_addr_ok at cycle 0, inst_data_ok with inst_rdata 0x02800c04 at cycle 3.
- inst_req and data read 0x80001000 in the same cycle -> data wins (arid 1, arsize 2); inst accepted only after data_data_ok.
- Byte store addr 0x80000003, wstrb 4'b1000, wdata 0x55000000; wready 2 cycles after awready -> awsize 0, bready after both handshakes, single data_data_ok 1 cycle after bvalid.
- Data write outstanding, then data read issued -> data_addr_ok held 0 until write data_data_ok; inst read in parallel completes meanwhile.
- Reset asserted while in R_R waiting for rvalid -> all valids, readys and ok outputs 0 immediately, no data_ok after release.
- rvalid with rid 4'd7 -> no data_ok on either port, FSM back in R_IDLE, next inst request accepted.
